// File: rtl/fb_vga_reader.sv
// fb_vga_reader: turns VGA 640x480 timing into 2x2-replicated reads of a 320x240 RGB565
// frame buffer and drives RGB444 to the pins, with sync/DE delayed to line up with the pixels.
// Latency: the read strobe is 1 cycle after the input; video, sync and DE are 2+READ_LATENCY
// cycles after the input. No backpressure: the pixel stream is free-running.
//
// Ports:
//   clk, reset            pixel clock, synchronous active-high reset
//   de_in/hsync_in/       incoming VGA timing and pixel coordinates
//   vsync_in/x_in/y_in
//   rEn/rAddr/rData       frame-buffer read port; rData is valid READ_LATENCY cycles after rEn
//   r_out/g_out/b_out     RGB444 video, black outside fetched pixels
//   hsync_out/vsync_out/  timing delayed to match the video
//   de_out
//   frame_done            one-cycle pulse after the last active line of a frame
//   test_mode             only with FB_READER_TEST_PATTERN_EN: 8 vertical colour bars, no reads
//
// Optional build macro: FB_READER_TEST_PATTERN_EN adds test_mode and the colour-bar generator.

module fb_vga_reader #(
  parameter int IMG_WIDTH    = 320,
  parameter int IMG_HEIGHT   = 240,
  parameter int READ_LATENCY = 1,
  parameter bit SYNC_IDLE    = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        de_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic [9:0]  x_in,
  input  logic [9:0]  y_in,
  output logic        rEn,
  output logic [16:0] rAddr,
  input  logic [15:0] rData,
`ifdef FB_READER_TEST_PATTERN_EN
  input  logic        test_mode,
`endif
  output logic [3:0]  r_out,
  output logic [3:0]  g_out,
  output logic [3:0]  b_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        de_out,
  output logic        frame_done
);

  // Delay-line depth: the read stage plus the memory latency.
  localparam int          DL        = 1 + READ_LATENCY;
  localparam logic [9:0]  X_LIMIT   = 10'(2 * IMG_WIDTH);
  localparam logic [9:0]  Y_LIMIT   = 10'(2 * IMG_HEIGHT);
  localparam logic [9:0]  Y_LAST    = 10'(2 * IMG_HEIGHT - 1);
  localparam logic [16:0] LINE_STEP = 17'(IMG_WIDTH);

  logic        armed;      // low after reset until de_in has been seen low once
  logic        de_prev;    // gated DE from the previous cycle
  logic [9:0]  last_y;     // row of the most recent active pixel
  logic [16:0] line_base;  // frame-buffer address of the current source line

  logic        eff_de;
  logic        in_range;
  logic        frame_start;
  logic        fetch;
  logic        line_end;
  logic        tm;
  logic [16:0] base_now;

  logic [DL-1:0] de_d;
  logic [DL-1:0] hs_d;
  logic [DL-1:0] vs_d;
  logic [DL-1:0] ren_d;

  // rData bits dropped by the 565 -> 444 truncation.
  logic unused_rdata_bits;
  assign unused_rdata_bits = ^{rData[11], rData[6:5], rData[0]};

`ifdef FB_READER_TEST_PATTERN_EN
  assign tm = test_mode;
`else
  assign tm = 1'b0;
`endif

  always_comb begin
    // Reset mid-line: a partial line is ignored until DE has been seen low.
    eff_de      = de_in & armed;
    in_range    = (x_in < X_LIMIT) & (y_in < Y_LIMIT);
    frame_start = eff_de & (x_in == 10'd0) & (y_in == 10'd0);
    fetch       = eff_de & in_range & ~tm;
    line_end    = de_prev & ~eff_de;
    // The re-seeding pixel itself must already use base 0, since line_base is
    // still one line past the end of the previous frame at that moment.
    base_now    = frame_start ? 17'd0 : line_base;
  end

  // Line tracking and read-address stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      armed      <= 1'b0;
      de_prev    <= 1'b0;
      last_y     <= 10'd0;
      line_base  <= 17'd0;
      rEn        <= 1'b0;
      rAddr      <= 17'd0;
      frame_done <= 1'b0;
    end else begin
      armed   <= armed | ~de_in;
      de_prev <= eff_de;
      if (eff_de) begin
        last_y <= y_in;
      end

      // Each source line is shown on two VGA rows; only the odd row advances.
      if (frame_start) begin
        line_base <= 17'd0;
      end else if (line_end && last_y[0]) begin
        line_base <= line_base + LINE_STEP;
      end

      rEn <= fetch;
      if (fetch) begin
        rAddr <= base_now + {8'd0, x_in[9:1]};
      end

      frame_done <= line_end & (last_y == Y_LAST);
    end
  end

  // Timing delay line. Stage 0 loads alongside rEn, so the last stage lines up
  // with rData.
  always_ff @(posedge clk) begin
    if (reset) begin
      de_d  <= '0;
      ren_d <= '0;
      hs_d  <= {DL{SYNC_IDLE}};
      vs_d  <= {DL{SYNC_IDLE}};
    end else begin
      de_d  <= {de_d[DL-2:0], eff_de};
      ren_d <= {ren_d[DL-2:0], fetch};
      hs_d  <= {hs_d[DL-2:0], hsync_in};
      vs_d  <= {vs_d[DL-2:0], vsync_in};
    end
  end

`ifdef FB_READER_TEST_PATTERN_EN
  logic [9:0]    x_d [DL];
  logic [DL-1:0] tm_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DL; i++) begin
        x_d[i] <= 10'd0;
      end
      tm_d <= '0;
    end else begin
      x_d[0] <= x_in;
      for (int i = 1; i < DL; i++) begin
        x_d[i] <= x_d[i-1];
      end
      tm_d <= {tm_d[DL-2:0], tm};
    end
  end

  // Eight bars, 80 VGA columns each.
  function automatic logic [11:0] bar_colour(input logic [9:0] col);
    if (col < 10'd80)       return 12'hFFF;
    else if (col < 10'd160) return 12'hFF0;
    else if (col < 10'd240) return 12'h0FF;
    else if (col < 10'd320) return 12'h0F0;
    else if (col < 10'd400) return 12'hF0F;
    else if (col < 10'd480) return 12'hF00;
    else if (col < 10'd560) return 12'h00F;
    else                    return 12'h000;
  endfunction
`endif

  // Output stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out     <= 4'd0;
      g_out     <= 4'd0;
      b_out     <= 4'd0;
      de_out    <= 1'b0;
      hsync_out <= SYNC_IDLE;
      vsync_out <= SYNC_IDLE;
    end else begin
      de_out    <= de_d[DL-1];
      hsync_out <= hs_d[DL-1];
      vsync_out <= vs_d[DL-1];
      if (ren_d[DL-1]) begin
        r_out <= rData[15:12];
        g_out <= rData[10:7];
        b_out <= rData[4:1];
`ifdef FB_READER_TEST_PATTERN_EN
      end else if (tm_d[DL-1] && de_d[DL-1]) begin
        {r_out, g_out, b_out} <= bar_colour(x_d[DL-1]);
`endif
      end else begin
        r_out <= 4'd0;
        g_out <= 4'd0;
        b_out <= 4'd0;
      end
    end
  end

endmodule

// File: tb/tb_fb_vga_reader.sv
// Bench for fb_vga_reader: two instances (READ_LATENCY 1 and 2) share one
// randomized timing stream; a reference model queues expected responses that a
// negedge monitor pops and compares.

module tb_fb_vga_reader;

  localparam int W = 320;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       de, hs, vs, tm;
  logic [9:0] x, y;

  logic        ren1, ren2;
  logic [16:0] addr1, addr2;
  logic [15:0] rd1, rd2a, rd2;
  logic [3:0]  r1, g1, b1, r2, g2, b2;
  logic        hso1, vso1, deo1, fd1, hso2, vso2, deo2, fd2;

  fb_vga_reader #(.READ_LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .de_in(de), .hsync_in(hs), .vsync_in(vs),
    .x_in(x), .y_in(y), .rEn(ren1), .rAddr(addr1), .rData(rd1),
`ifdef FB_READER_TEST_PATTERN_EN
    .test_mode(tm),
`endif
    .r_out(r1), .g_out(g1), .b_out(b1), .hsync_out(hso1), .vsync_out(vso1),
    .de_out(deo1), .frame_done(fd1)
  );

  fb_vga_reader #(.READ_LATENCY(2)) dut2 (
    .clk(clk), .reset(reset), .de_in(de), .hsync_in(hs), .vsync_in(vs),
    .x_in(x), .y_in(y), .rEn(ren2), .rAddr(addr2), .rData(rd2),
`ifdef FB_READER_TEST_PATTERN_EN
    .test_mode(tm),
`endif
    .r_out(r2), .g_out(g2), .b_out(b2), .hsync_out(hso2), .vsync_out(vso2),
    .de_out(deo2), .frame_done(fd2)
  );

  // Frame-buffer contents: a hash of the address, with F81F planted at the
  // word shown at x=10,y=0.
  function automatic logic [15:0] mem_word(input logic [16:0] a);
    logic [31:0] h;
    if (a == 17'd5) return 16'hF81F;
    h = {15'd0, a} * 32'd2654435761;
    return h[31:16] ^ h[15:0];
  endfunction

  always @(posedge clk) begin
    rd1  <= mem_word(addr1);
    rd2a <= mem_word(addr2);
    rd2  <= rd2a;
  end

  typedef struct {
    int          due;
    logic        ren;
    logic [16:0] addr;
    logic        fd;
    logic [3:0]  r, g, b;
    logic        de, hs, vs;
  } exp_t;

  exp_t q0[$], q1[$], q2[$];
  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  bit checking = 0;
  logic [11:0] bars [8];

  // Reference model state.
  bit m_armed, m_prev;
  int m_last_y;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s cycle %0d: got %h, expected %h", nm, cyc, act, exp);
    end
  endtask

  // Expected response of one input cycle, from the pixel-replication rules.
  function automatic exp_t model(input int t);
    exp_t e;
    int xi, yi, idx;
    logic [15:0] d;
    bit eff;
    xi  = int'(x);
    yi  = int'(y);
    eff = de && m_armed;
    e.due  = t;
    e.ren  = eff && xi < 640 && yi < 480 && !tm;
    e.addr = 17'((yi / 2) * W + xi / 2);
    e.fd   = m_prev && !eff && (m_last_y == 479);
    e.de   = eff;
    e.hs   = hs;
    e.vs   = vs;
    {e.r, e.g, e.b} = 12'h000;
    if (e.ren) begin
      d = mem_word(e.addr);
      e.r = d[15:12];
      e.g = d[10:7];
      e.b = d[4:1];
    end else if (tm && eff) begin
      idx = xi / 80;
      if (idx > 7) idx = 7;
      {e.r, e.g, e.b} = bars[idx];
    end
    if (eff) m_last_y = yi;
    m_prev  = eff;
    m_armed = m_armed || !de;
    return e;
  endfunction

  task automatic drive(input bit d, input int xx, input int yy);
    exp_t e;
    @(posedge clk);
    #1;
    de = d;
    x  = 10'(xx);
    y  = 10'(yy);
    hs = 1'($urandom_range(0, 1));
    vs = 1'($urandom_range(0, 1));
    e = model(cyc);
    e.due = cyc + 1; q0.push_back(e);
    e.due = cyc + 3; q1.push_back(e);
    e.due = cyc + 4; q2.push_back(e);
  endtask

  task automatic gap(input int yy);
    repeat ($urandom_range(2, 5)) drive(0, $urandom_range(0, 1023), yy);
  endtask

  task automatic run_frame();
    for (int yy = 0; yy < 480; yy++) begin
      if (yy < 4 || yy >= 478) begin
        for (int xx = 0; xx < 640; xx++) drive(1, xx, yy);
      end else begin
        int len, xs, xx;
        len = $urandom_range(1, 12);   // length 1 exercises a one-cycle DE glitch
        xs  = $urandom_range(1, 639);
        for (int k = 0; k < len; k++) begin
          xx = xs + k;
          if ($urandom_range(0, 15) == 0) xx = $urandom_range(640, 1023);
          drive(1, xx, yy);
        end
      end
      gap(yy);
    end
    // Out-of-range row after the frame: no reads, no frame_done.
    for (int k = 0; k < 4; k++) drive(1, 100 + k, 480);
    gap(480);
  endtask

  // Monitor.
  always @(negedge clk) begin
    if (checking) begin
      while (q0.size() > 0 && q0[0].due <= cyc) begin
        exp_t e;
        e = q0.pop_front();
        if (e.due < cyc) chk("missed_s0", 1, 0);
        chk("rEn1", ren1, e.ren);
        chk("rEn2", ren2, e.ren);
        chk("frame_done1", fd1, e.fd);
        chk("frame_done2", fd2, e.fd);
        if (e.ren) begin
          chk("rAddr1", addr1, e.addr);
          chk("rAddr2", addr2, e.addr);
        end
      end
      while (q1.size() > 0 && q1[0].due <= cyc) begin
        exp_t e;
        e = q1.pop_front();
        if (e.due < cyc) chk("missed_o1", 1, 0);
        chk("rgb1", {r1, g1, b1}, {e.r, e.g, e.b});
        chk("de_out1", deo1, e.de);
        chk("hsync_out1", hso1, e.hs);
        chk("vsync_out1", vso1, e.vs);
      end
      while (q2.size() > 0 && q2[0].due <= cyc) begin
        exp_t e;
        e = q2.pop_front();
        if (e.due < cyc) chk("missed_o2", 1, 0);
        chk("rgb2", {r2, g2, b2}, {e.r, e.g, e.b});
        chk("de_out2", deo2, e.de);
        chk("hsync_out2", hso2, e.hs);
        chk("vsync_out2", vso2, e.vs);
      end
    end
  end

  initial begin
    bars[0] = 12'hFFF; bars[1] = 12'hFF0; bars[2] = 12'h0FF; bars[3] = 12'h0F0;
    bars[4] = 12'hF0F; bars[5] = 12'hF00; bars[6] = 12'h00F; bars[7] = 12'h000;
    reset = 1'b1;
    de = 1'b1; hs = 1'b0; vs = 1'b0; tm = 1'b0;
    x = 10'd0; y = 10'd0;

    // Reset held during active video.
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      x  = 10'($urandom_range(0, 639));
      y  = 10'($urandom_range(0, 479));
      hs = 1'($urandom_range(0, 1));
      vs = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("rst_rgb1", {r1, g1, b1}, 12'h000);
      chk("rst_rgb2", {r2, g2, b2}, 12'h000);
      chk("rst_de", {deo1, deo2}, 2'b00);
      chk("rst_sync", {hso1, vso1, hso2, vso2}, 4'b1111);
      chk("rst_frame_done", {fd1, fd2}, 2'b00);
      chk("rst_rEn", {ren1, ren2}, 2'b00);
      chk("rst_rAddr", {addr1, addr2}, 34'd0);
    end
    reset = 1'b0;
    m_armed = 0;
    m_prev = 0;
    m_last_y = 0;
    checking = 1;

    // Rest of a line already in progress at reset: must stay blank.
    for (int k = 0; k < 5; k++) drive(1, 200 + k, 7);
    gap(7);

    run_frame();
    run_frame();

`ifdef FB_READER_TEST_PATTERN_EN
    tm = 1'b1;
    drive(1, 0, 0);
    drive(1, 85, 0);
    drive(1, 639, 0);
    for (int k = 0; k < 16; k++) drive(1, $urandom_range(0, 639), 0);
    gap(0);
    tm = 1'b0;
`endif

    repeat (8) drive(0, 0, 0);
    repeat (8) @(posedge clk);
    if (q0.size() + q1.size() + q2.size() != 0) chk("queue_drain", q0.size() + q1.size() + q2.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
